// File: rtl/udma_eth_tx_framer.sv
// Fetches frame words over the uDMA TX channel and serializes them little-endian
// onto an 8-bit AXI-Stream feed for the MAC, with optional min-size padding and clean abort.
module udma_eth_tx_framer #(
  parameter int LEN_WIDTH = 16,
  parameter bit PAD_EN    = 1'b1,
  parameter int MIN_FRAME = 60
) (
  input  logic                 sys_clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_start_i,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 cfg_abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic                 err_o,
  output logic                 data_tx_req_o,
  input  logic                 data_tx_gnt_i,
  input  logic [31:0]          data_tx_i,
  input  logic                 data_tx_valid_i,
  output logic                 data_tx_ready_o,
  output logic [7:0]           tx_axis_tdata_o,
  output logic                 tx_axis_tvalid_o,
  input  logic                 tx_axis_tready_i,
  output logic                 tx_axis_tlast_o,
  output logic                 tx_axis_tuser_o
);
  typedef enum logic [1:0] {IDLE, DATA, PAD, DRAIN} state_e;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_FRAME);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [LEN_WIDTH:0]   words_q, words_d, reqs_q, reqs_d;
  logic [1:0]           outst_q, outst_d, cnt_q, cnt_d, sel_q, sel_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 abort_q, abort_d, done_q, done_d, aborted_q, aborted_d, err_q, err_d;
  logic [31:0]          buf_q [2];
  logic [31:0]          head;
  logic                 push, pop, hs, last_data, pad_need, req, rdy, tvalid, tlast;

  assign head      = buf_q[rd_ptr_q];
  assign pad_need  = PAD_EN && (len_q < MIN_LEN);
  assign last_data = (byte_cnt_q == len_q - ONE);
  // Credit rule: buffered plus in-flight words never exceed the 2-entry buffer.
  assign req    = (state_q == DATA) && (reqs_q < words_q) &&
                  (({1'b0, cnt_q} + {1'b0, outst_q}) < 3'd2);
  assign rdy    = ((state_q == DATA) && (cnt_q != 2'd2)) || (state_q == DRAIN);
  assign push   = (state_q == DATA) && data_tx_valid_i && rdy;
  assign tvalid = ((state_q == DATA) && (cnt_q != 2'd0)) || (state_q == PAD);
  assign tlast  = tvalid && (abort_q ||
                  ((state_q == DATA) && last_data && !pad_need) ||
                  ((state_q == PAD) && (byte_cnt_q == MIN_LEN - ONE)));
  assign hs     = tvalid && tx_axis_tready_i;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    reqs_d     = reqs_q + {{LEN_WIDTH{1'b0}}, req && data_tx_gnt_i};
    outst_d    = outst_q + {1'b0, req && data_tx_gnt_i} - {1'b0, data_tx_valid_i && rdy};
    byte_cnt_d = byte_cnt_q;
    sel_d      = sel_q;
    pop        = 1'b0;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q;
    abort_d    = abort_q || (cfg_abort_i && ((state_q == DATA) || (state_q == PAD)));
    done_d     = 1'b0;
    aborted_d  = aborted_q;
    err_d      = cfg_start_i && (busy_o || (cfg_len_i == '0));
    case (state_q)
      IDLE: begin
        if (cfg_start_i && !done_q && (cfg_len_i != '0)) begin
          state_d    = DATA;
          len_d      = cfg_len_i;
          words_d    = ({1'b0, cfg_len_i} + (LEN_WIDTH+1)'(3)) >> 2;
          reqs_d     = '0;
          byte_cnt_d = '0;
          sel_d      = 2'd0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
          aborted_d  = 1'b0;
          abort_d    = 1'b0;
        end
      end
      DATA, PAD: begin
        if (hs) begin
          byte_cnt_d = byte_cnt_q + ONE;
          if (state_q == DATA) begin
            // The final word pops as soon as len bytes are out; its tail is dropped.
            sel_d = sel_q + 2'd1;
            if ((sel_q == 2'd3) || last_data) begin
              pop      = 1'b1;
              sel_d    = 2'd0;
              rd_ptr_d = ~rd_ptr_q;
            end
          end
          if (tlast) begin
            abort_d = 1'b0;
            if (abort_q) begin
              state_d = DRAIN;
            end else begin
              state_d   = IDLE;
              done_d    = 1'b1;
              aborted_d = 1'b0;
            end
          end else if ((state_q == DATA) && last_data) begin
            state_d = PAD;
          end
        end
      end
      DRAIN: begin
        if (outst_q == 2'd0) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (state_d == DRAIN) begin
      cnt_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      words_q    <= '0;
      reqs_q     <= '0;
      byte_cnt_q <= '0;
      outst_q    <= 2'd0;
      cnt_q      <= 2'd0;
      sel_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      reqs_q     <= reqs_d;
      byte_cnt_q <= byte_cnt_d;
      outst_q    <= outst_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
      if (push) buf_q[wr_ptr_q] <= data_tx_i;
    end
  end

  always_comb begin
    tx_axis_tdata_o = 8'h00;
    if (state_q == DATA) begin
      case (sel_q)
        2'd0:    tx_axis_tdata_o = head[7:0];
        2'd1:    tx_axis_tdata_o = head[15:8];
        2'd2:    tx_axis_tdata_o = head[23:16];
        default: tx_axis_tdata_o = head[31:24];
      endcase
    end
  end

  assign busy_o           = (state_q != IDLE) || done_q;
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;
  assign err_o            = err_q;
  assign data_tx_req_o    = req;
  assign data_tx_ready_o  = rdy;
  assign tx_axis_tvalid_o = tvalid;
  assign tx_axis_tlast_o  = tlast;
  assign tx_axis_tuser_o  = tvalid && abort_q;
endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Directed bench: instance 0 pads to 60 bytes, instance 1 has padding disabled.
module tb_udma_eth_tx_framer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_start = 1'b0, cfg_abort = 1'b0, tready = 1'b1;
  logic [15:0] cfg_len = '0;
  logic        busy [2], done [2], aborted [2], err [2], req [2], rdy [2];
  logic        tvalid [2], tlast [2], tuser [2], dvalid [2];
  logic [7:0]  tdata [2];
  logic [31:0] ddata [2];
  logic [31:0] mem [0:31];

  udma_eth_tx_framer #(.LEN_WIDTH(16), .PAD_EN(1'b1), .MIN_FRAME(60)) u_pad (
    .sys_clk_i(clk), .rstn_i(rstn), .cfg_start_i(cfg_start), .cfg_len_i(cfg_len),
    .cfg_abort_i(cfg_abort), .busy_o(busy[0]), .done_o(done[0]), .aborted_o(aborted[0]),
    .err_o(err[0]), .data_tx_req_o(req[0]), .data_tx_gnt_i(1'b1), .data_tx_i(ddata[0]),
    .data_tx_valid_i(dvalid[0]), .data_tx_ready_o(rdy[0]), .tx_axis_tdata_o(tdata[0]),
    .tx_axis_tvalid_o(tvalid[0]), .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast[0]),
    .tx_axis_tuser_o(tuser[0]));

  udma_eth_tx_framer #(.LEN_WIDTH(16), .PAD_EN(1'b0), .MIN_FRAME(60)) u_nopad (
    .sys_clk_i(clk), .rstn_i(rstn), .cfg_start_i(cfg_start), .cfg_len_i(cfg_len),
    .cfg_abort_i(cfg_abort), .busy_o(busy[1]), .done_o(done[1]), .aborted_o(aborted[1]),
    .err_o(err[1]), .data_tx_req_o(req[1]), .data_tx_gnt_i(1'b1), .data_tx_i(ddata[1]),
    .data_tx_valid_i(dvalid[1]), .data_tx_ready_o(rdy[1]), .tx_axis_tdata_o(tdata[1]),
    .tx_axis_tvalid_o(tvalid[1]), .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast[1]),
    .tx_axis_tuser_o(tuser[1]));

  // uDMA responder (grant always, data one cycle later) plus byte/stall monitor.
  logic [31:0] pend [2][$];
  logic [9:0]  blog [2][$];
  int          widx [2], grants [2], stall_err [2], fgr [2], fby [2], max_infl [2];
  logic        prev_stall [2];
  logic [9:0]  prev_beat [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int g = 0; g < 2; g++) begin
        pend[g].delete();
        widx[g] = 0;
        dvalid[g] <= 1'b0;
        ddata[g] <= '0;
        prev_stall[g] <= 1'b0;
        prev_beat[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (cfg_start && !busy[g]) begin
          widx[g] = 0;
          fgr[g] = 0;
          fby[g] = 0;
        end
        if (dvalid[g] && rdy[g]) void'(pend[g].pop_front());
        if (req[g]) begin
          pend[g].push_back(mem[widx[g] % 32]);
          widx[g]++;
          grants[g]++;
          fgr[g]++;
        end
        dvalid[g] <= (pend[g].size() != 0);
        ddata[g] <= (pend[g].size() != 0) ? pend[g][0] : 32'h0;
        if (tvalid[g] && tready) begin
          blog[g].push_back({tuser[g], tlast[g], tdata[g]});
          fby[g]++;
        end
        if (fgr[g] - fby[g] / 4 > max_infl[g]) max_infl[g] = fgr[g] - fby[g] / 4;
        if (prev_stall[g] && (!tvalid[g] || ({tuser[g], tlast[g], tdata[g]} != prev_beat[g])))
          stall_err[g]++;
        prev_stall[g] <= tvalid[g] && !tready;
        prev_beat[g] <= {tuser[g], tlast[g], tdata[g]};
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] outs(input int g);
    return {busy[g], done[g], aborted[g], err[g], req[g], rdy[g], tvalid[g], tlast[g],
            tuser[g], tdata[g]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int len);
    cfg_len = 16'(len);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int n = 0;
    while (!done[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 0);
  endtask

  task automatic chk_frame(input int g, input int base, input int len, input int total,
                           input string tag);
    int bad = 0;
    logic [9:0] e;
    logic [31:0] w;
    chk({tag, "_nbytes"}, blog[g].size() - base, total);
    for (int i = 0; i < total && base + i < blog[g].size(); i++) begin
      w = mem[i / 4];
      e = {1'b0, (i == total - 1), (i < len) ? w[8 * (i % 4) +: 8] : 8'h00};
      if (blog[g][base + i] !== e) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++)
      mem[i] = {8'(4 * i + 4), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1)};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, g0, g1, s0, s1, n, req_hi;
    logic prev_tl, seen0, seen1;
    logic [7:0] exp_b [8];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    fill_mem();

    // Reset
    step(2);
    chk("reset_outs0", 32'(outs(0)), 0);
    chk("reset_outs1", 32'(outs(1)), 0);
    rstn = 1'b1;
    step(2);
    chk("idle_outs0", 32'(outs(0)), 0);

    // Basic frame on the no-pad instance: len=8
    b1 = blog[1].size(); g1 = grants[1];
    start(8);
    chk("basic_busy", 32'(busy[1]), 1);
    chk("basic_req", 32'(req[1]), 1);
    prev_tl = 1'b0; n = 0;
    while (!done[1] && n < 200) begin
      prev_tl = tvalid[1] && tready && tlast[1];
      @(negedge clk);
      n++;
    end
    chk("basic_timeout", 32'(n >= 200), 0);
    chk("basic_done_lat", 32'(prev_tl), 1);
    chk("basic_aborted", 32'(aborted[1]), 0);
    chk("basic_busy_at_done", 32'(busy[1]), 1);
    chk("basic_nbytes", blog[1].size() - b1, 8);
    for (int i = 0; i < 8 && b1 + i < blog[1].size(); i++)
      chk("basic_byte", 32'(blog[1][b1 + i]), 32'({1'b0, (i == 7), exp_b[i]}));
    chk("basic_grants", grants[1] - g1, 2);
    step(1);
    chk("basic_busy_after", 32'(busy[1]), 0);
    chk("basic_done_pulse", 32'(done[1]), 0);
    wait_done(0, 300, "basic_padinst");
    step(2);

    // Truncation and padding: len=5
    mem[0] = 32'h44332211; mem[1] = 32'h88776655; mem[2] = 32'hDEADBEEF;
    b0 = blog[0].size(); b1 = blog[1].size(); g0 = grants[0]; g1 = grants[1];
    start(5);
    wait_done(0, 300, "pad");
    chk_frame(0, b0, 5, 60, "pad");
    chk("pad_byte4", 32'(blog[0][b0 + 4]), 32'h055);
    chk("pad_byte5", 32'(blog[0][b0 + 5]), 32'h000);
    chk("pad_byte60", 32'(blog[0][b0 + 59]), 32'h100);
    chk("pad_grants", grants[0] - g0, 2);
    chk("pad_aborted", 32'(aborted[0]), 0);
    chk_frame(1, b1, 5, 5, "trunc");
    chk("trunc_last", 32'(blog[1][b1 + 4]), 32'h155);
    chk("trunc_grants", grants[1] - g1, 2);
    step(2);
    fill_mem();

    // Backpressure: len=64 with random tready
    b0 = blog[0].size(); b1 = blog[1].size(); g0 = grants[0]; g1 = grants[1];
    s0 = stall_err[0]; s1 = stall_err[1];
    start(64);
    seen0 = 1'b0; seen1 = 1'b0; n = 0;
    while (!(seen0 && seen1) && n < 3000) begin
      tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (done[0]) seen0 = 1'b1;
      if (done[1]) seen1 = 1'b1;
    end
    tready = 1'b1;
    chk("bp_timeout", 32'(n >= 3000), 0);
    chk_frame(0, b0, 64, 64, "bp0");
    chk_frame(1, b1, 64, 64, "bp1");
    chk("bp_stall0", stall_err[0] - s0, 0);
    chk("bp_stall1", stall_err[1] - s1, 0);
    chk("bp_grants0", grants[0] - g0, 16);
    chk("bp_grants1", grants[1] - g1, 16);
    chk("bp_inflight0", 32'(max_infl[0] <= 2), 1);
    chk("bp_inflight1", 32'(max_infl[1] <= 2), 1);
    step(2);

    // Abort at byte 10 of len=64
    b0 = blog[0].size();
    start(64);
    n = 0;
    while (blog[0].size() - b0 < 9 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_timeout", 32'(n >= 200), 0);
    tready = 1'b0;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abort_beat", 32'({tvalid[0], tuser[0], tlast[0], tdata[0]}), 32'h70A);
    tready = 1'b1;
    @(negedge clk);
    req_hi = 0; n = 0;
    while (!done[0] && n < 100) begin
      if (req[0]) req_hi++;
      @(negedge clk);
      n++;
    end
    chk("abort_done_timeout", 32'(n >= 100), 0);
    chk("abort_req_drain", req_hi, 0);
    chk("abort_aborted", 32'(aborted[0]), 1);
    chk("abort_pending_words", pend[0].size(), 0);
    chk("abort_nbytes", blog[0].size() - b0, 10);
    chk("abort_last", 32'(blog[0][b0 + 9]), 32'h30A);
    step(20);
    chk("abort_no_more", blog[0].size() - b0, 10);
    chk("abort_idle_tvalid", 32'(tvalid[0]), 0);

    // Rejected starts
    start(0);
    chk("rej_len0_err", 32'(err[0]), 1);
    chk("rej_len0_busy", 32'(busy[0]), 0);
    step(1);
    chk("rej_len0_err_pulse", 32'(err[0]), 0);
    b1 = blog[1].size(); g1 = grants[1];
    start(8);
    step(3);
    start(20);
    chk("rej_busy_err", 32'(err[1]), 1);
    chk("rej_busy_busy", 32'(busy[1]), 1);
    wait_done(1, 200, "rej_busy");
    chk_frame(1, b1, 8, 8, "rej_busy");
    chk("rej_busy_grants", grants[1] - g1, 2);
    wait_done(0, 300, "rej_busy_padinst");
    step(2);

    // Reset mid-frame, then a len=4 frame
    start(64);
    step(12);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_outs0", 32'(outs(0)), 0);
    chk("rst_mid_outs1", 32'(outs(1)), 0);
    b1 = blog[1].size();
    step(3);
    chk("rst_mid_quiet", blog[1].size() - b1, 0);
    rstn = 1'b1;
    step(1);
    b0 = blog[0].size(); b1 = blog[1].size();
    start(4);
    wait_done(1, 200, "post_rst");
    chk_frame(1, b1, 4, 4, "post_rst");
    wait_done(0, 300, "post_rst_pad");
    chk_frame(0, b0, 4, 60, "post_rst_pad");
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
